bcd_countdown_timer: RTL



---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_dec_digit.sv | 29 ++
 rtl/bcd_countdown_timer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD types, constants and helpers for the game's digit counters.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam bcd_digit_t BCD_ZERO = 4'd0;

    // Force an arbitrary nibble into the legal BCD range; 10..15 become 9.
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t nibble);
        if (nibble > BCD_MAX) begin
            return BCD_MAX;
        end else begin
            return nibble;
        end
    endfunction

endpackage

// File: rtl/bcd_dec_digit.sv
// Combinational single-digit BCD decrement with borrow; chained ones->tens->hundreds.
module bcd_dec_digit
    import bcd_pkg::*;
(
    input  bcd_digit_t digit,
    input  logic       borrow_in,
    output bcd_digit_t digit_next,
    output logic       borrow_out
);

    // A digit at zero underflows to nine and passes the borrow upward.
    always_comb begin
        digit_next = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == BCD_ZERO) begin
                digit_next = BCD_MAX;
                borrow_out = 1'b1;
            end else begin
                digit_next = digit - 4'd1;
                borrow_out = 1'b0;
            end
        end else begin
            digit_next = digit;
            borrow_out = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Three-digit BCD countdown timer (999..000) for the round time-limit display.
// A prescaler turns clk into countdown steps; a rising edge on dec applies a
// one-off penalty decrement. The count saturates at 000 and pulses done once.
module bcd_countdown_timer
    import bcd_pkg::*;
#(
    parameter int DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_hund,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    input  logic       start,
    input  logic       pause,
    input  logic       dec,
    output logic [3:0] dig_hund,
    output logic [3:0] dig_tens,
    output logic [3:0] dig_ones,
    output logic       running,
    output logic       zero,
    output logic       done
);

    localparam int            PW         = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    bcd_digit_t    hund_r;
    bcd_digit_t    tens_r;
    bcd_digit_t    ones_r;
    logic          running_r;
    logic          done_r;
    logic [PW-1:0] presc_r;
    logic          dec_prev_r;

    bcd_digit_t    hund_next_s;
    bcd_digit_t    tens_next_s;
    bcd_digit_t    ones_next_s;
    logic          borrow_ones_s;
    logic          borrow_tens_s;
    logic          borrow_hund_s;

    logic          dec_req_s;
    logic          step_s;
    logic          dec_any_s;
    logic          count_zero_s;
    logic          count_one_s;

    // The chain always computes count-1; the sequential block decides whether to commit it.
    bcd_dec_digit u_dec_ones (
        .digit      (ones_r),
        .borrow_in  (1'b1),
        .digit_next (ones_next_s),
        .borrow_out (borrow_ones_s)
    );

    bcd_dec_digit u_dec_tens (
        .digit      (tens_r),
        .borrow_in  (borrow_ones_s),
        .digit_next (tens_next_s),
        .borrow_out (borrow_tens_s)
    );

    bcd_dec_digit u_dec_hund (
        .digit      (hund_r),
        .borrow_in  (borrow_tens_s),
        .digit_next (hund_next_s),
        .borrow_out (borrow_hund_s)
    );

    // Decode edge request, prescaler terminal count and the 000/001 conditions.
    always_comb begin
        dec_req_s    = dec & ~dec_prev_r;
        step_s       = running_r & (presc_r == PRESC_LAST);
        dec_any_s    = step_s | dec_req_s;
        count_zero_s = (hund_r == BCD_ZERO) & (tens_r == BCD_ZERO) & (ones_r == BCD_ZERO);
        count_one_s  = (hund_r == BCD_ZERO) & (tens_r == BCD_ZERO) & (ones_r == 4'd1);
    end

    // Counter state: load > pause > start > step/dec, with saturation at 000.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hund_r     <= BCD_ZERO;
            tens_r     <= BCD_ZERO;
            ones_r     <= BCD_ZERO;
            running_r  <= 1'b0;
            done_r     <= 1'b0;
            presc_r    <= '0;
            dec_prev_r <= 1'b0;
        end else begin
            dec_prev_r <= dec;
            done_r     <= 1'b0;
            if (load) begin
                hund_r    <= bcd_clamp(load_hund);
                tens_r    <= bcd_clamp(load_tens);
                ones_r    <= bcd_clamp(load_ones);
                running_r <= 1'b0;
                presc_r   <= '0;
            end else if (pause) begin
                // Prescaler is deliberately kept so a resume finishes the partial period.
                running_r <= 1'b0;
            end else if (start) begin
                if (!count_zero_s) begin
                    running_r <= 1'b1;
                end else begin
                    running_r <= running_r;
                end
            end else begin
                if (running_r) begin
                    if (step_s) begin
                        presc_r <= '0;
                    end else begin
                        presc_r <= presc_r + PW'(1);
                    end
                end else begin
                    presc_r <= presc_r;
                end
                // A coincident step and dec request still consume only one count.
                if (dec_any_s && !count_zero_s) begin
                    hund_r <= hund_next_s;
                    tens_r <= tens_next_s;
                    ones_r <= ones_next_s;
                    if (count_one_s) begin
                        done_r    <= 1'b1;
                        running_r <= 1'b0;
                    end else begin
                        done_r <= 1'b0;
                    end
                end else begin
                    done_r <= 1'b0;
                end
            end
        end
    end

    assign dig_hund = hund_r;
    assign dig_tens = tens_r;
    assign dig_ones = ones_r;
    assign running  = running_r;
    assign done     = done_r;
    assign zero     = count_zero_s;

endmodule
